mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl.sv | 149 ++++++++++++++
 tb/tb_mmio_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// Memory-mapped board I/O: HEX/LEDR registers, debounced KEY data with ready/overrun status, and switch data.
// Define MMIO_SW_DEBOUNCE_EN to debounce the switches as well; by default SDATA is only synchronized.

module mmio_ctrl_debounce #(
    parameter int             W      = 4,
    parameter int             CYCLES = 100000,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         accept
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CYCLES - 1);

    logic [W-1:0]  last;
    logic [CW-1:0] cnt;

    // A candidate is accepted only on an edge where it is still held and still differs from stable.
    assign accept = (cnt == CNT_TOP) && (din == last) && (din != stable);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last   <= RST_VAL;
            stable <= RST_VAL;
            cnt    <= '0;
        end else begin
            last <= din;
            if (accept)
                stable <= din;
            if ((din != last) || (din == stable))
                cnt <= '0;
            else if (cnt != CNT_TOP)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module mmio_ctrl #(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    output logic             io_sel,
    output logic [DBITS-1:0] rdata,
    output logic [15:0]      hex_out,
    output logic [9:0]       ledr_out
);
    localparam logic [11:0] A_HEX  = 12'h000;
    localparam logic [11:0] A_LEDR = 12'h004;
    localparam logic [11:0] A_KD   = 12'h010;
    localparam logic [11:0] A_SD   = 12'h014;
    localparam logic [11:0] A_KC   = 12'h110;

    logic [3:0] key_s1, key_s2, key_stable;
    logic [9:0] sw_s1, sw_s2, sdata;
    logic       key_acc;
    logic       ready, overrun;
    logic       kd_rd, ovr_clr, hex_we, ledr_we;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[DBITS-1:16];

    assign io_sel  = (addr[31:12] == 20'hF0000);
    assign hex_we  = wr_en && io_sel && (addr[11:0] == A_HEX);
    assign ledr_we = wr_en && io_sel && (addr[11:0] == A_LEDR);
    assign kd_rd   = rd_en && io_sel && (addr[11:0] == A_KD);
    assign ovr_clr = wr_en && io_sel && (addr[11:0] == A_KC) && !wdata[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    // Keys idle high, so the stable raw state resets to all-ones (KDATA = 0).
    mmio_ctrl_debounce #(
        .W(4), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(4'hF)
    ) u_key_db (
        .clk(clk), .reset(reset), .din(key_s2), .stable(key_stable), .accept(key_acc)
    );

`ifdef MMIO_SW_DEBOUNCE_EN
    logic unused_sw_acc;
    mmio_ctrl_debounce #(
        .W(10), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(10'h0)
    ) u_sw_db (
        .clk(clk), .reset(reset), .din(sw_s2), .stable(sdata), .accept(unused_sw_acc)
    );
`else
    assign sdata = sw_s2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_out  <= '0;
            ledr_out <= '0;
            ready    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (hex_we)
                hex_out <= wdata[15:0];
            if (ledr_we)
                ledr_out <= wdata[9:0];
            // A new key value wins over a concurrent read or overrun clear.
            if (key_acc)
                ready <= 1'b1;
            else if (kd_rd)
                ready <= 1'b0;
            if (key_acc && kd_rd)
                overrun <= overrun;
            else if (key_acc && ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (addr[11:0])
                A_HEX:   rdata[15:0] = hex_out;
                A_LEDR:  rdata[9:0]  = ledr_out;
                A_KD:    rdata[3:0]  = ~key_stable;
                A_SD:    rdata[9:0]  = sdata;
                A_KC:    rdata[2:0]  = {overrun, 1'b0, ready};
                default: rdata       = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Randomized self-checking bench for mmio_ctrl against a cycle-level behavioural model.
module tb_mmio_ctrl;
    localparam int DC = 4;
    localparam logic [31:0] A_HEX  = 32'hF000_0000;
    localparam logic [31:0] A_LEDR = 32'hF000_0004;
    localparam logic [31:0] A_KD   = 32'hF000_0010;
    localparam logic [31:0] A_SD   = 32'hF000_0014;
    localparam logic [31:0] A_KC   = 32'hF000_0110;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        wr_en, rd_en, io_sel;
    logic [3:0]  key_in;
    logic [9:0]  sw_in;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;

    int total = 0;
    int bad   = 0;

    // Model state: registers, key/switch values as seen 1 and 2 edges ago, run length of the
    // delayed key value, accepted raw key state, status bits.
    logic [15:0] m_hex;
    logic [9:0]  m_ledr, sd1, sd2;
    logic [3:0]  kd1, kd2, kval, kstab;
    int          krun;
    logic        m_ready, m_ovr;

    mmio_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
        .key_in(key_in), .sw_in(sw_in), .io_sel(io_sel), .rdata(rdata),
        .hex_out(hex_out), .ledr_out(ledr_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a[31:12] != 20'hF0000) return 32'h0;
        case (a)
            A_HEX:   return {16'h0, m_hex};
            A_LEDR:  return {22'h0, m_ledr};
            A_KD:    return {28'h0, ~kstab};
            A_SD:    return {22'h0, sd2};
            A_KC:    return {29'h0, m_ovr, 1'b0, m_ready};
            default: return 32'h0;
        endcase
    endfunction

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic tick();
        logic acc, rd_kd, clr, nrdy, novr;
        if (kd2 == kval) krun = (krun < 1000) ? krun + 1 : krun;
        else begin kval = kd2; krun = 1; end
        acc   = (krun == DC + 1) && (kval != kstab);
        rd_kd = rd_en && (addr == A_KD);
        clr   = wr_en && (addr == A_KC) && !wdata[2];
        nrdy  = acc ? 1'b1 : (rd_kd ? 1'b0 : m_ready);
        if (acc && rd_kd)        novr = m_ovr;
        else if (acc && m_ready) novr = 1'b1;
        else if (clr)            novr = 1'b0;
        else                     novr = m_ovr;
        m_ready = nrdy;
        m_ovr   = novr;
        if (acc) kstab = kval;
        if (wr_en && addr == A_HEX)  m_hex  = wdata[15:0];
        if (wr_en && addr == A_LEDR) m_ledr = wdata[9:0];
        kd2 = kd1; kd1 = key_in;
        sd2 = sd1; sd1 = sw_in;
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        m_hex = '0; m_ledr = '0; sd1 = '0; sd2 = '0;
        kd1 = 4'hF; kd2 = 4'hF; kval = 4'hF; kstab = 4'hF; krun = 0;
        m_ready = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] regs [5];
        regs = '{A_HEX, A_LEDR, A_KD, A_SD, A_KC};
        key_in = 4'hE;
        sw_in  = 10'h3FF;
        assert_reset();
        @(posedge clk); #1;
        total++; if (hex_out !== 16'h0) begin bad++; $display("FAIL reset_hex: got %h want 0", hex_out); end
        total++; if (ledr_out !== 10'h0) begin bad++; $display("FAIL reset_ledr: got %h want 0", ledr_out); end
        foreach (regs[i]) begin
            addr = regs[i]; #1;
            total++;
            if (rdata !== 32'h0) begin bad++; $display("FAIL reset_reg %h: got %h want 0", regs[i], rdata); end
        end
        key_in = 4'hF;
        sw_in  = 10'h0;
        release_reset();
    endtask

    task automatic test_regs();
        addr = A_HEX;  wdata = 32'h1234; wr_en = 1'b1; tick();
        total++; if (hex_out !== 16'h1234) begin bad++; $display("FAIL hex_write: got %h want 1234", hex_out); end
        addr = A_LEDR; wdata = 32'h3FF; tick();
        wr_en = 1'b0;
        total++; if (ledr_out !== 10'h3FF) begin bad++; $display("FAIL ledr_write: got %h want 3ff", ledr_out); end
        addr = A_HEX; rd_en = 1'b1; #1;
        total++; if (rdata !== 32'h1234) begin bad++; $display("FAIL hex_load: got %h want 1234", rdata); end
        addr = A_LEDR; #1;
        total++; if (rdata !== 32'h3FF) begin bad++; $display("FAIL ledr_load: got %h want 3ff", rdata); end
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr  = ($urandom_range(0, 1) == 0) ? A_HEX : A_LEDR;
            wdata = $urandom;
            wr_en = 1'b1;
            tick();
            wr_en = 1'b0; #1;
            total++;
            if (hex_out !== m_hex || ledr_out !== m_ledr || rdata !== model_rd(addr)) begin
                bad++;
                $display("FAIL reg_rand %0d: hex %h/%h ledr %h/%h rdata %h/%h", i,
                         hex_out, m_hex, ledr_out, m_ledr, rdata, model_rd(addr));
            end
        end
    endtask

    task automatic test_key_press();
        key_in = 4'hE;
        addr   = A_KD;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (rdata !== model_rd(A_KD)) begin
                bad++; $display("FAIL key_lat cyc%0d: got %h want %h", i, rdata, model_rd(A_KD));
            end
        end
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL key_kdata: got %h want 1", rdata); end
        addr = A_KC; #1;
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL key_ready: got %h want 1", rdata); end
        addr = A_KD; rd_en = 1'b1; tick();
        rd_en = 1'b0; addr = A_KC; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL key_rdclr: got %h want 0", rdata); end
    endtask

    task automatic test_glitch();
        assert_reset();
        key_in = 4'hF;
        release_reset();
        tick();
        key_in = 4'hE; tick(); tick();
        key_in = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        addr = A_KD; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL glitch_kdata: got %h want 0", rdata); end
        addr = A_KC; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL glitch_ready: got %h want 0", rdata); end
    endtask

    task automatic test_overrun();
        addr = A_SD;
        key_in = 4'hE; for (int i = 0; i < 8; i++) tick();
        key_in = 4'hC; for (int i = 0; i < 8; i++) tick();
        addr = A_KD; #1;
        total++; if (rdata !== 32'h3) begin bad++; $display("FAIL ovr_kdata: got %h want 3", rdata); end
        addr = A_KC; #1;
        total++; if (rdata !== 32'h5) begin bad++; $display("FAIL ovr_set: got %h want 5", rdata); end
        wdata = 32'h0; wr_en = 1'b1; tick();
        wr_en = 1'b0; #1;
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL ovr_clear: got %h want 1", rdata); end
    endtask

    task automatic test_unmapped();
        logic [15:0] hex_before;
        hex_before = hex_out;
        addr = 32'hF000_0020; rd_en = 1'b1; #1;
        total++; if (io_sel !== 1'b1 || rdata !== 32'h0) begin
            bad++; $display("FAIL unmapped_io: io_sel %b rdata %h want 1 0", io_sel, rdata);
        end
        addr = 32'h0000_0100; #1;
        total++; if (io_sel !== 1'b0 || rdata !== 32'h0) begin
            bad++; $display("FAIL non_io: io_sel %b rdata %h want 0 0", io_sel, rdata);
        end
        rd_en = 1'b0;
        wdata = {16'h0, ~hex_before}; wr_en = 1'b1;
        addr = 32'hF000_0020; tick();
        addr = 32'h0000_0000; tick();
        wr_en = 1'b0;
        total++; if (hex_out !== hex_before) begin bad++; $display("FAIL unmapped_wr: got %h want %h", hex_out, hex_before); end
    endtask

    task automatic test_reset_mid();
        addr = A_HEX; wdata = 32'hBEEF; wr_en = 1'b1; tick();
        wr_en = 1'b0;
        key_in = 4'h7;
        for (int i = 0; i < 4; i++) tick();
        assert_reset();
        total++; if (hex_out !== 16'h0 || ledr_out !== 10'h0) begin
            bad++; $display("FAIL midrst_out: hex %h ledr %h want 0 0", hex_out, ledr_out);
        end
        addr = A_KD; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midrst_kdata: got %h want 0", rdata); end
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (rdata !== model_rd(A_KD)) begin
                bad++; $display("FAIL midrst_redb cyc%0d: got %h want %h", i, rdata, model_rd(A_KD));
            end
        end
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL midrst_final: got %h want 8", rdata); end
    endtask

    task automatic test_random();
        logic [31:0] amap [7];
        amap = '{A_HEX, A_LEDR, A_KD, A_SD, A_KC, 32'hF000_0020, 32'h0000_0100};
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) key_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) sw_in  = 10'($urandom);
            addr  = amap[$urandom_range(0, 6)];
            rd_en = ($urandom_range(0, 2) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            #1;
            total++;
            if (io_sel !== (addr[31:12] == 20'hF0000) || rdata !== model_rd(addr) ||
                hex_out !== m_hex || ledr_out !== m_ledr) begin
                bad++;
                $display("FAIL rand cyc%0d addr %h: io_sel %b rdata %h/%h hex %h/%h ledr %h/%h",
                         i, addr, io_sel, rdata, model_rd(addr), hex_out, m_hex, ledr_out, m_ledr);
            end
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
        key_in = 4'hF; sw_in = '0;
        test_reset();
        test_regs();
        test_key_press();
        test_glitch();
        test_overrun();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
